rs_mult_seq: RTL and testbench

Parametrised sequential right-shift (shift-add) multiplier. It is the successor of the fixed 6-bit single-step multiplier.
- Latches both operands internally, sequences WIDTH add/shift steps with its own step counter and FSM, and reports the product through a start/busy/done handshake.
- Sits between a controlling FSM or bench and any datapath that needs a 2*WIDTH-bit product at low area.

---
 rtl/rs_mult_seq.sv | 118 +++++++++++
 tb/tb_rs_mult_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rs_mult_seq
//  Purpose  : Sequential right-shift (shift-add) multiplier, WIDTH steps per
//             product, start/busy/done handshake. Define SIGNED_MULT_EN for
//             two's-complement operands via radix-2 Booth recoding.
//  Revision : 1.0  initial release
// ============================================================================
module rs_mult_seq #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic [CNT_W-1:0]     count_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_xs;
    logic [WIDTH-1:0]     r_ys;
    logic [2*WIDTH-1:0]   r_p;
    logic [CNT_W-1:0]     r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH:0]       w_sum;
    logic                 w_last;

    // Only the upper half of P takes part in the add; the lower half just shifts.
`ifdef SIGNED_MULT_EN
    logic r_xprev;

    always_comb begin
        w_sum = {r_p[2*WIDTH-1], r_p[2*WIDTH-1:WIDTH]};
        case ({r_xs[0], r_xprev})
            2'b01:   w_sum = {r_p[2*WIDTH-1], r_p[2*WIDTH-1:WIDTH]} + {r_ys[WIDTH-1], r_ys};
            2'b10:   w_sum = {r_p[2*WIDTH-1], r_p[2*WIDTH-1:WIDTH]} - {r_ys[WIDTH-1], r_ys};
            default: w_sum = {r_p[2*WIDTH-1], r_p[2*WIDTH-1:WIDTH]};
        endcase
    end
`else
    assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_xs[0] ? {1'b0, r_ys} : '0);
`endif

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_count <= '0;
            r_xs    <= '0;
            r_ys    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SIGNED_MULT_EN
            r_xprev <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_xs    <= X;
                        r_ys    <= Y;
                        r_p     <= '0;
                        r_count <= '0;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`ifdef SIGNED_MULT_EN
                        r_xprev <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The carry/sign bit of the sum becomes the new MSB of P.
                    r_p     <= {w_sum, r_p[WIDTH-1:1]};
                    r_xs    <= r_xs >> 1;
                    r_count <= r_count + 1'b1;
`ifdef SIGNED_MULT_EN
                    r_xprev <= r_xs[0];
`endif
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign P         = r_p;
    assign count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rs_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_mult_seq
//  Purpose  : Self-checking bench for rs_mult_seq against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_mult_seq;
    localparam int WIDTH = 6;
    localparam int CNT_W = 7;
    localparam int PW    = 2 * WIDTH;
    localparam int TMO   = 4 * WIDTH + 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   X;
    logic [WIDTH-1:0]   Y;
    logic               busy;
    logic               done;
    logic [PW-1:0]      P;
    logic [CNT_W-1:0]   count_out;

    int n_checks = 0;
    int n_fail   = 0;

    rs_mult_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .P         (P),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint ea;
        longint eb;
`ifdef SIGNED_MULT_EN
        ea = longint'($signed(a));
        eb = longint'($signed(b));
`else
        ea = longint'({1'b0, a});
        eb = longint'({1'b0, b});
`endif
        return PW'(ea * eb);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; operands are scrambled after accept.
    task automatic run_mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            output logic [PW-1:0] p, output logic [CNT_W-1:0] cnt,
                            output int lat, output int nbusy, output bit to);
        start = 1'b1; X = x; Y = y;
        tick;
        start = 1'b0;
        X = WIDTH'($urandom); Y = WIDTH'($urandom);
        lat = 0; nbusy = 0;
        while (done !== 1'b1 && lat < TMO) begin
            if (busy === 1'b1) nbusy++;
            tick;
            lat++;
        end
        to  = (done !== 1'b1);
        p   = P;
        cnt = count_out;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        tick; tick;
        rst = 1'b0;
        n_checks++; if (P !== '0) begin n_fail++; $display("FAIL reset_P: got %0h expected 0", P); end
        n_checks++; if (count_out !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] xs [5] = '{6'd63, 6'd0, 6'd45, 6'd1, 6'd37};
        logic [WIDTH-1:0] ys [5] = '{6'd63, 6'd45, 6'd0, 6'd37, 6'd1};
        logic [PW-1:0] p, exp_p;
        logic [CNT_W-1:0] cnt;
        int lat, nb;
        bit to;
        for (int i = 0; i < 5; i++) begin
            exp_p = ref_product(xs[i], ys[i]);
            run_mult(xs[i], ys[i], p, cnt, lat, nb, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL dir_timeout[%0d]: no done within %0d cycles", i, TMO); end
            n_checks++; if (p !== exp_p) begin n_fail++; $display("FAIL dir_P[%0d]: got %0h expected %0h", i, p, exp_p); end
            n_checks++; if (cnt !== CNT_W'(WIDTH)) begin n_fail++; $display("FAIL dir_count[%0d]: got %0d expected %0d", i, cnt, WIDTH); end
            n_checks++; if (lat != WIDTH) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, WIDTH); end
            n_checks++; if (nb != WIDTH) begin n_fail++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, nb, WIDTH); end
            tick;
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dir_idle_flags[%0d]: got done=%b busy=%b expected 0/0", i, done, busy); end
            n_checks++; if (P !== exp_p) begin n_fail++; $display("FAIL dir_P_hold[%0d]: got %0h expected %0h", i, P, exp_p); end
            n_checks++; if (count_out !== CNT_W'(WIDTH)) begin n_fail++; $display("FAIL dir_count_hold[%0d]: got %0d expected %0d", i, count_out, WIDTH); end
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] x, y;
        logic [PW-1:0] p, exp_p;
        logic [CNT_W-1:0] cnt;
        int lat, nb;
        bit to;
        for (int i = 0; i < 30; i++) begin
            x = WIDTH'($urandom); y = WIDTH'($urandom);
            exp_p = ref_product(x, y);
            run_mult(x, y, p, cnt, lat, nb, to);
            n_checks++; if (p !== exp_p || to) begin n_fail++; $display("FAIL rnd_P[%0d]: x=%0h y=%0h got %0h expected %0h", i, x, y, p, exp_p); end
            n_checks++; if (lat != WIDTH || cnt !== CNT_W'(WIDTH)) begin n_fail++; $display("FAIL rnd_timing[%0d]: got lat=%0d cnt=%0d expected %0d", i, lat, cnt, WIDTH); end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick;
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        start = 1'b1; X = 6'd5; Y = 6'd7;
        tick;
        start = 1'b0;
        tick; tick;
        start = 1'b1; X = 6'd9; Y = 6'd9;
        tick;
        start = 1'b0; X = '0; Y = '0;
        lat = 3;
        while (done !== 1'b1 && lat < TMO) begin tick; lat++; end
        n_checks++; if (lat != WIDTH) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", lat, WIDTH); end
        n_checks++; if (P !== ref_product(6'd5, 6'd7)) begin n_fail++; $display("FAIL ign_P: got %0h expected %0h", P, ref_product(6'd5, 6'd7)); end
        tick;
    endtask

    task automatic test_reset_abort;
        bit saw_done;
        logic [PW-1:0] p;
        logic [CNT_W-1:0] cnt;
        int lat, nb;
        bit to;
        start = 1'b1; X = 6'd50; Y = 6'd60;
        tick;
        start = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (P !== '0 || count_out !== '0) begin n_fail++; $display("FAIL abort_state: got P=%0h cnt=%0d expected 0/0", P, count_out); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got busy=%b done=%b expected 0/0", busy, done); end
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            tick;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got activity after reset expected none"); end
        run_mult(6'd3, 6'd4, p, cnt, lat, nb, to);
        n_checks++; if (p !== ref_product(6'd3, 6'd4) || to) begin n_fail++; $display("FAIL abort_next_P: got %0h expected %0h", p, ref_product(6'd3, 6'd4)); end
        tick;
    endtask

    task automatic test_back_to_back;
        int lat;
        start = 1'b1; X = 6'd12; Y = 6'd11;
        tick;
        X = WIDTH'($urandom); Y = WIDTH'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin tick; lat++; end
        n_checks++; if (lat != WIDTH) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, WIDTH); end
        n_checks++; if (P !== ref_product(6'd12, 6'd11)) begin n_fail++; $display("FAIL b2b_first_P: got %0h expected %0h", P, ref_product(6'd12, 6'd11)); end
        X = 6'd7; Y = 6'd9;
        tick;
        n_checks++; if (busy !== 1'b1 || count_out !== '0) begin n_fail++; $display("FAIL b2b_no_bubble: got busy=%b cnt=%0d expected 1/0", busy, count_out); end
        X = WIDTH'($urandom); Y = WIDTH'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < TMO) begin tick; lat++; end
        start = 1'b0;
        n_checks++; if (lat != WIDTH + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", lat, WIDTH + 1); end
        n_checks++; if (P !== ref_product(6'd7, 6'd9)) begin n_fail++; $display("FAIL b2b_second_P: got %0h expected %0h", P, ref_product(6'd7, 6'd9)); end
        tick;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

`ifdef SIGNED_MULT_EN
    task automatic test_signed;
        logic [WIDTH-1:0] xs [3] = '{6'h20, 6'h3F, 6'h1F};
        logic [WIDTH-1:0] ys [3] = '{6'h20, 6'h1F, 6'h20};
        logic [PW-1:0]    ex [3] = '{12'h400, 12'hFE1, 12'hC20};
        logic [PW-1:0] p;
        logic [CNT_W-1:0] cnt;
        int lat, nb;
        bit to;
        for (int i = 0; i < 3; i++) begin
            run_mult(xs[i], ys[i], p, cnt, lat, nb, to);
            n_checks++; if (p !== ex[i] || to) begin n_fail++; $display("FAIL signed_P[%0d]: got %0h expected %0h", i, p, ex[i]); end
            tick;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
`ifdef SIGNED_MULT_EN
        test_signed;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
